// File: rtl/mips_cpu_mem_pkg.sv
// Shared types for the MIPS CPU-side memory controller: access sizes,
// controller states and the registered request record.
package mips_cpu_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    CAPTURE,
    DONE
  } mem_ctrl_state_t;

  // Size is kept as raw bits so the illegal encoding 2'b11 can be held as-is.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic size_legal(input logic [1:0] size);
    return size != 2'b11;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_lane_align.sv
// Combinational lane steering for one 32-bit bus beat: byte enables,
// replicated store data, alignment check and load-data extraction/extension.
module mips_cpu_mem_lane_align
  import mips_cpu_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misaligned,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Decode lanes, replicate store data and right-justify/extend load data.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    byteenable = '0;
    writedata  = '0;
    misaligned = 1'b0;
    rdata      = '0;
    shifted    = readdata >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << lane;
        writedata  = {4{wdata[7:0]}};
        rdata      = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byteenable = 4'b0011 << lane;
        writedata  = {2{wdata[15:0]}};
        misaligned = lane[0];
        rdata      = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        byteenable = 4'b1111;
        writedata  = wdata;
        misaligned = |lane;
        rdata      = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_ctrl.sv
// CPU-side memory controller: turns one load/store request into a single
// aligned Avalon-style transaction and returns an extended result or error.
// Optional: define MEM_CTRL_TIMEOUT_EN to abort a BUS phase stalled for
// TIMEOUT_CYCLES cycles with an error response.
module mips_cpu_mem_ctrl
  import mips_cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  mem_ctrl_state_t state_q, state_d;
  mem_req_t        req_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic        in_idle, in_bus, req_take, req_bad, timeout;
  logic [1:0]  al_size, al_lane;
  logic [3:0]  al_ben;
  logic [31:0] al_wd, al_rdata;
  logic        al_misaligned;

  assign in_idle  = (state_q == IDLE);
  assign in_bus   = (state_q == BUS);
  assign req_take = in_idle & req_valid;

  // The alignment check needs the live request in IDLE; later phases use the held copy.
  assign al_size = in_idle ? req_size      : req_q.size;
  assign al_lane = in_idle ? req_addr[1:0] : req_q.addr[1:0];
  assign req_bad = al_misaligned | ~size_legal(req_size);

  mips_cpu_mem_lane_align u_lane_align (
    .size       (al_size),
    .lane       (al_lane),
    .sign_ext   (req_q.sign_ext),
    .wdata      (req_q.wdata),
    .readdata   (avm_readdata),
    .byteenable (al_ben),
    .writedata  (al_wd),
    .misaligned (al_misaligned),
    .rdata      (al_rdata)
  );

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q;

  // Count stalled BUS cycles; restarts with every newly taken request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         wait_cnt_q <= '0;
    else if (req_take)                 wait_cnt_q <= '0;
    else if (in_bus && avm_waitrequest) wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = in_bus & avm_waitrequest & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register; async reset drops the bus strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the IDLE -> BUS -> (CAPTURE) -> DONE sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_bad ? DONE : BUS;
      BUS: begin
        if (timeout)               state_d = DONE;
        else if (!avm_waitrequest) state_d = req_q.write ? DONE : CAPTURE;
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request hold register and response result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (req_take) begin
      req_q   <= '{write: req_write, size: req_size, sign_ext: req_signed,
                   addr: req_addr, wdata: req_wdata};
      err_q   <= req_bad;
      rdata_q <= '0;
    end else if (timeout) begin
      err_q   <= 1'b1;
    end else if (state_q == CAPTURE) begin
      rdata_q <= al_rdata;
    end
  end

  assign req_ready      = in_idle;
  assign avm_read       = in_bus & ~req_q.write;
  assign avm_write      = in_bus &  req_q.write;
  assign avm_address    = in_bus ? {req_q.addr[31:2], 2'b00} : '0;
  assign avm_byteenable = in_bus ? al_ben : '0;
  assign avm_writedata  = avm_write ? al_wd : '0;
  assign resp_valid     = (state_q == DONE);
  assign resp_err       = resp_valid & err_q;
  assign resp_rdata     = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Self-checking bench for mips_cpu_mem_ctrl: directed vector table, reset
// abort, optional timeout case and randomised traffic against a byte-level model.
`timescale 1ns/1ps
module tb_mips_cpu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;

  always #5 clk = ~clk;

  mips_cpu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- RAM slave (16 words, address bits [5:2]) ----------------
  logic [31:0] mem_words [16];
  int          stall_cnt = 0;
  bit          rand_wait = 1'b0;

  always @(posedge clk) begin
    bit took_read;
    took_read = 1'b0;
    if ((avm_read || avm_write) && !avm_waitrequest) begin
      if (avm_write) begin
        for (int b = 0; b < 4; b++)
          if (avm_byteenable[b]) mem_words[avm_address[5:2]][8*b +: 8] = avm_writedata[8*b +: 8];
      end else begin
        avm_readdata = mem_words[avm_address[5:2]];
        took_read = 1'b1;
      end
    end
    #2;
    if (!took_read) avm_readdata = $urandom;
    avm_waitrequest = (stall_cnt > 0) || (rand_wait && ($urandom_range(0, 3) == 0));
    if ((avm_read || avm_write) && stall_cnt > 0) stall_cnt--;
  end

  // ---------------- Reference model: flat byte memory ----------------
  logic [7:0] ref_mem [64];

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    logic [3:0]  ben;
    logic [31:0] wd;
  } exp_t;

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic exp_t ref_expect(input bit wr, input logic [1:0] sz, input bit sg,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          n, base;
    logic [31:0] v;
    e = '{err: 1'b0, rdata: '0, ben: '0, wd: '0};
    n = size_bytes(sz);
    base = int'(addr[5:0]);
    if (sz == 2'd3 || (base % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    for (int k = 0; k < n; k++) e.ben[(base % 4) + k] = 1'b1;
    if (wr) begin
      for (int b = 0; b < 4; b++) e.wd[8*b +: 8] = wdata[8*(b % n) +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base + k];
      if (sg && v[8*n-1])
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < size_bytes(sz); k++) ref_mem[int'(addr[5:0]) + k] = wdata[8*k +: 8];
  endtask

  // ---------------- Request driver / bus observer ----------------
  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          bus_cycles;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wd;
    bit          saw_rd, saw_wr, both, unstable, hung;
  } obs_t;

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
    int n, acc_n;
    o = '{err: 1'b0, rdata: '0, lat: 0, bus_cycles: 0, addr: '0, ben: '0, wd: '0,
          saw_rd: 1'b0, saw_wr: 1'b0, both: 1'b0, unstable: 1'b0, hung: 1'b1};
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    acc_n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      if (avm_read || avm_write) begin
        if (o.bus_cycles == 0) begin
          o.addr = avm_address; o.ben = avm_byteenable; o.wd = avm_writedata;
        end else if (avm_address !== o.addr || avm_byteenable !== o.ben ||
                     (avm_write && avm_writedata !== o.wd)) begin
          o.unstable = 1'b1;
        end
        o.bus_cycles++;
        if (avm_read)  o.saw_rd = 1'b1;
        if (avm_write) o.saw_wr = 1'b1;
        if (avm_read && avm_write) o.both = 1'b1;
        if (!avm_waitrequest) acc_n = n;
      end
      if (resp_valid) begin
        o.err = resp_err; o.rdata = resp_rdata; o.lat = n - acc_n; o.hung = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input exp_t e, input obs_t o);
    check({tag, " no_response"}, o.hung, 1'b0);
    check({tag, " resp_err"}, o.err, e.err);
    check({tag, " resp_rdata"}, o.rdata, e.rdata);
    check({tag, " latency"}, o.lat, e.err ? 1 : (wr ? 2'd1 : 2'd2));
    if (e.err) begin
      check({tag, " bus_cycles"}, o.bus_cycles, 0);
    end else begin
      check({tag, " address"}, o.addr, {addr[31:2], 2'b00});
      check({tag, " byteenable"}, o.ben, e.ben);
      if (wr) check({tag, " writedata"}, o.wd, e.wd);
      check({tag, " read_strobe"}, o.saw_rd, !wr);
      check({tag, " write_strobe"}, o.saw_wr, wr);
      check({tag, " both_strobes"}, o.both, 1'b0);
      check({tag, " held_stable"}, o.unstable, 1'b0);
    end
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    bit          err;
    logic [31:0] rdata;
    logic [3:0]  ben;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    obs_t o;
    exp_t e;

    vecs[0]  = '{0, 2'd2, 0, 32'hBFC00004, 32'h0,        3, 0, 32'h11223344, 4'hF, 32'h0};
    vecs[1]  = '{1, 2'd2, 0, 32'hBFC00004, 32'h80FF0102, 0, 0, 32'h0,        4'hF, 32'h80FF0102};
    vecs[2]  = '{0, 2'd0, 1, 32'hBFC00007, 32'h0,        1, 0, 32'hFFFFFF80, 4'h8, 32'h0};
    vecs[3]  = '{0, 2'd0, 0, 32'hBFC00007, 32'h0,        0, 0, 32'h00000080, 4'h8, 32'h0};
    vecs[4]  = '{0, 2'd1, 1, 32'hBFC00004, 32'h0,        0, 0, 32'h00000102, 4'h3, 32'h0};
    vecs[5]  = '{0, 2'd1, 0, 32'hBFC00006, 32'h0,        2, 0, 32'h000080FF, 4'hC, 32'h0};
    vecs[6]  = '{0, 2'd1, 1, 32'hBFC00006, 32'h0,        0, 0, 32'hFFFF80FF, 4'hC, 32'h0};
    vecs[7]  = '{1, 2'd1, 0, 32'hBFC00002, 32'h0000ABCD, 2, 0, 32'h0,        4'hC, 32'hABCDABCD};
    vecs[8]  = '{0, 2'd2, 0, 32'hBFC00000, 32'h0,        0, 0, 32'hABCD7788, 4'hF, 32'h0};
    vecs[9]  = '{1, 2'd0, 0, 32'hBFC00001, 32'h12345699, 0, 0, 32'h0,        4'h2, 32'h99999999};
    vecs[10] = '{0, 2'd2, 0, 32'hBFC00000, 32'h0,        0, 0, 32'hABCD9988, 4'hF, 32'h0};
    vecs[11] = '{0, 2'd1, 1, 32'hBFC00001, 32'h0,        0, 1, 32'h0,        4'h0, 32'h0};
    vecs[12] = '{0, 2'd2, 0, 32'hBFC00002, 32'h0,        0, 1, 32'h0,        4'h0, 32'h0};
    vecs[13] = '{0, 2'd3, 0, 32'hBFC00000, 32'h0,        0, 1, 32'h0,        4'h0, 32'h0};
    vecs[14] = '{1, 2'd2, 0, 32'hBFC00001, 32'hDEADBEEF, 0, 1, 32'h0,        4'h0, 32'h0};
    vecs[15] = '{0, 2'd2, 0, 32'hBFC00000, 32'h0,        0, 0, 32'hABCD9988, 4'hF, 32'h0};

    for (int w = 0; w < 16; w++) mem_words[w] = $urandom;
    mem_words[0] = 32'h55667788;
    mem_words[1] = 32'h11223344;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_words[w][8*b +: 8];

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset req_ready", req_ready, 1'b1);
    check("reset resp_valid", resp_valid, 1'b0);
    check("reset avm_read", avm_read, 1'b0);
    check("reset avm_write", avm_write, 1'b0);
    check("reset avm_byteenable", avm_byteenable, 4'h0);
    check("reset avm_address", avm_address, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table, deterministic waitrequest.
    rand_wait = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stall_cnt = vecs[i].stall;
      do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata, o);
      e = '{err: vecs[i].err, rdata: vecs[i].rdata, ben: vecs[i].ben, wd: vecs[i].wd};
      check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, e, o);
      if (!vecs[i].err) check($sformatf("vec%0d bus_cycles", i), o.bus_cycles, vecs[i].stall + 1);
      if (vecs[i].wr && !vecs[i].err) ref_store(vecs[i].sz, vecs[i].addr, vecs[i].wdata);
    end

    // Reset in the middle of a stalled read: strobes fall without a clock edge.
    while (!req_ready) @(negedge clk);
    stall_cnt = 20;
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'hBFC00008; req_wdata = '0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort read before reset", avm_read, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort avm_read", avm_read, 1'b0);
    check("abort avm_write", avm_write, 1'b0);
    check("abort avm_byteenable", avm_byteenable, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    stall_cnt = 0;
    @(negedge clk);
    check("abort req_ready", req_ready, 1'b1);
    check("abort resp_valid", resp_valid, 1'b0);

`ifdef MEM_CTRL_TIMEOUT_EN
    // Waitrequest stuck high: the controller gives up after 16 BUS cycles.
    stall_cnt = 1000;
    do_req(1'b0, 2'd2, 1'b0, 32'hBFC00004, 32'h0, o);
    check("timeout no_response", o.hung, 1'b0);
    check("timeout resp_err", o.err, 1'b1);
    check("timeout resp_rdata", o.rdata, 32'h0);
    check("timeout bus_cycles", o.bus_cycles, 16);
    stall_cnt = 0;
    @(negedge clk);
`endif

    // Randomised traffic against the byte-level model.
    rand_wait = 1'b1;
    for (int i = 0; i < 150; i++) begin
      bit          wr, sg;
      logic [1:0]  sz;
      logic [31:0] addr, wdata;
      int          off;
      wr    = 1'($urandom_range(0, 1));
      sg    = 1'($urandom_range(0, 1));
      sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      off   = $urandom_range(0, 63);
      if ($urandom_range(0, 9) < 7) off = off - (off % size_bytes(sz));
      addr  = 32'hBFC00000 + 32'(off);
      wdata = $urandom;
      e = ref_expect(wr, sz, sg, addr, wdata);
      do_req(wr, sz, sg, addr, wdata, o);
      check_txn($sformatf("rand%0d", i), wr, addr, e, o);
      if (wr && !e.err) ref_store(sz, addr, wdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
